// File: rtl/sobel_edge_detect_if.sv
// Window stream into the Sobel stage and the edge pixel stream out of it.
// The master drives windows; the slave (the Sobel stage) drives edge results.
interface sobel_edge_detect_if;
   logic        matrix_frame_wr_en;
   logic [7:0]  matrix_p11;
   logic [7:0]  matrix_p12;
   logic [7:0]  matrix_p13;
   logic [7:0]  matrix_p21;
   logic [7:0]  matrix_p22;
   logic [7:0]  matrix_p23;
   logic [7:0]  matrix_p31;
   logic [7:0]  matrix_p32;
   logic [7:0]  matrix_p33;
   logic [7:0]  threshold;
   logic        edge_wr_en;
   logic [7:0]  edge_mag;
   logic [7:0]  edge_out;
   logic        edge_frame_done;
   logic [19:0] edge_count;

   modport master (
      output matrix_frame_wr_en, matrix_p11, matrix_p12, matrix_p13,
             matrix_p21, matrix_p22, matrix_p23,
             matrix_p31, matrix_p32, matrix_p33, threshold,
      input  edge_wr_en, edge_mag, edge_out, edge_frame_done, edge_count
   );

   modport slave (
      input  matrix_frame_wr_en, matrix_p11, matrix_p12, matrix_p13,
             matrix_p21, matrix_p22, matrix_p23,
             matrix_p31, matrix_p32, matrix_p33, threshold,
      output edge_wr_en, edge_mag, edge_out, edge_frame_done, edge_count
   );
endinterface

// File: rtl/sobel_edge_detect.sv
// Three-stage pipelined Sobel gradient magnitude with threshold, plus per-frame
// output position tracking and edge-pixel counting.
module sobel_edge_detect #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
) (
   input logic               clk,
   input logic               rst_n,
   sobel_edge_detect_if.slave sif
);

   localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
   localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

   function automatic logic [9:0] weighted_sum(input logic [7:0] a, input logic [7:0] b,
                                               input logic [7:0] c);
      return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
   endfunction

   // Magnitude of a difference taken as larger minus smaller, so it never wraps.
   function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
      return (a >= b) ? (a - b) : (b - a);
   endfunction

   logic [9:0]       gx_pos_s, gx_neg_s, gy_pos_s, gy_neg_s;
   logic             v1_r, v2_r;
   logic [9:0]       gx_pos_r, gx_neg_r, gy_pos_r, gy_neg_r;
   logic [7:0]       thr1_r, thr2_r;
   logic [9:0]       abs_gx_r, abs_gy_r;
   logic [10:0]      sum_s;
   logic [7:0]       mag_s;
   logic             is_edge_s;
   logic             last_col_s, last_row_s;
   logic             edge_wr_en_r, frame_done_r;
   logic [7:0]       edge_mag_r, edge_out_r;
   logic [19:0]      edge_count_r, run_r;
   logic [COL_W-1:0] col_r;
   logic [ROW_W-1:0] row_r;

   assign gx_pos_s = weighted_sum(sif.matrix_p13, sif.matrix_p23, sif.matrix_p33);
   assign gx_neg_s = weighted_sum(sif.matrix_p11, sif.matrix_p21, sif.matrix_p31);
   assign gy_pos_s = weighted_sum(sif.matrix_p31, sif.matrix_p32, sif.matrix_p33);
   assign gy_neg_s = weighted_sum(sif.matrix_p11, sif.matrix_p12, sif.matrix_p13);

   // Stage 1: partial sums and the threshold that belongs to this window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_r     <= 1'b0;
         gx_pos_r <= 10'd0;
         gx_neg_r <= 10'd0;
         gy_pos_r <= 10'd0;
         gy_neg_r <= 10'd0;
         thr1_r   <= 8'd0;
      end else begin
         v1_r <= sif.matrix_frame_wr_en;
         if (sif.matrix_frame_wr_en) begin
            gx_pos_r <= gx_pos_s;
            gx_neg_r <= gx_neg_s;
            gy_pos_r <= gy_pos_s;
            gy_neg_r <= gy_neg_s;
            thr1_r   <= sif.threshold;
         end
      end
   end

   // Stage 2: absolute gradients.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2_r     <= 1'b0;
         abs_gx_r <= 10'd0;
         abs_gy_r <= 10'd0;
         thr2_r   <= 8'd0;
      end else begin
         v2_r <= v1_r;
         if (v1_r) begin
            abs_gx_r <= abs_diff(gx_pos_r, gx_neg_r);
            abs_gy_r <= abs_diff(gy_pos_r, gy_neg_r);
            thr2_r   <= thr1_r;
         end
      end
   end

   assign sum_s      = {1'b0, abs_gx_r} + {1'b0, abs_gy_r};
   assign mag_s      = (sum_s >= 11'd255) ? 8'hFF : sum_s[7:0];
   assign is_edge_s  = (mag_s > thr2_r);
   assign last_col_s = (col_r == COL_W'(IMG_WIDTH - 1));
   assign last_row_s = (row_r == ROW_W'(IMG_HEIGHT - 1));

   // Stage 3: saturated magnitude and binary edge pixel; values hold between valids.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edge_wr_en_r <= 1'b0;
         edge_mag_r   <= 8'd0;
         edge_out_r   <= 8'd0;
      end else begin
         edge_wr_en_r <= v2_r;
         if (v2_r) begin
            edge_mag_r <= mag_s;
            edge_out_r <= is_edge_s ? 8'hFF : 8'h00;
         end
      end
   end

   // Frame position and edge counting, advanced with every emitted pixel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_r        <= '0;
         row_r        <= '0;
         run_r        <= 20'd0;
         edge_count_r <= 20'd0;
         frame_done_r <= 1'b0;
      end else begin
         frame_done_r <= v2_r && last_col_s && last_row_s;
         if (v2_r) begin
            if (last_col_s && last_row_s) begin
               edge_count_r <= run_r + {19'd0, is_edge_s};
               run_r        <= 20'd0;
               col_r        <= '0;
               row_r        <= '0;
            end else begin
               run_r <= run_r + {19'd0, is_edge_s};
               if (last_col_s) begin
                  col_r <= '0;
                  row_r <= row_r + ROW_W'(1);
               end else begin
                  col_r <= col_r + COL_W'(1);
               end
            end
         end
      end
   end

   assign sif.edge_wr_en      = edge_wr_en_r;
   assign sif.edge_mag        = edge_mag_r;
   assign sif.edge_out        = edge_out_r;
   assign sif.edge_frame_done = frame_done_r;
   assign sif.edge_count      = edge_count_r;

endmodule

// File: tb/tb_sobel_edge_detect.sv
// Directed vectors with hand-computed results for sobel_edge_detect, plus a
// cycle-by-cycle reference monitor for latency, streaming and frame accounting.
module tb_sobel_edge_detect;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks    = 0;
   int   n_fail      = 0;
   int   stream_outs = 0;
   logic stream_phase = 1'b0;

   always #5 clk = ~clk;

   sobel_edge_detect_if mif ();

   sobel_edge_detect #(.IMG_WIDTH(4), .IMG_HEIGHT(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sif   (mif)
   );

   // Window packing: w[0]=p11, w[1]=p12, w[2]=p13, w[3]=p21 ... w[8]=p33.
   localparam logic [8:0][7:0] FLAT   = {9{8'd100}};
   localparam logic [8:0][7:0] VSTEP  = {8'hFF, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00,
                                         8'hFF, 8'hFF, 8'h00};
   localparam logic [8:0][7:0] STEP3  = {8'd20, 8'd15, 8'd10, 8'd20, 8'd15, 8'd10,
                                         8'd20, 8'd15, 8'd10};
   localparam logic [8:0][7:0] CORNER = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                                         8'h00, 8'h00, 8'hFF};

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] ref_mag(input logic [8:0][7:0] w);
      int a [9];
      int gx, gy, s;
      for (int k = 0; k < 9; k++) a[k] = int'(w[k]);
      gx = (a[2] + 2 * a[5] + a[8]) - (a[0] + 2 * a[3] + a[6]);
      gy = (a[6] + 2 * a[7] + a[8]) - (a[0] + 2 * a[1] + a[2]);
      s  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      return (s > 255) ? 8'hFF : 8'(s);
   endfunction

   task automatic drive(input logic [8:0][7:0] w, input logic [7:0] thr);
      mif.matrix_p11 = w[0]; mif.matrix_p12 = w[1]; mif.matrix_p13 = w[2];
      mif.matrix_p21 = w[3]; mif.matrix_p22 = w[4]; mif.matrix_p23 = w[5];
      mif.matrix_p31 = w[6]; mif.matrix_p32 = w[7]; mif.matrix_p33 = w[8];
      mif.threshold  = thr;
      mif.matrix_frame_wr_en = 1'b1;
   endtask

   task automatic idle();
      mif.matrix_frame_wr_en = 1'b0;
      mif.threshold          = 8'h00;
   endtask

   // One window; result must appear exactly after the third edge, for one cycle.
   task automatic directed(input string tag, input logic [8:0][7:0] w, input logic [7:0] thr,
                           input logic [7:0] exp_mag, input logic [7:0] exp_out);
      @(negedge clk); drive(w, thr);
      @(negedge clk); idle();
      @(posedge clk); #1;
      check({tag, "_early"}, mif.edge_wr_en, 1'b0);
      @(posedge clk); #1;
      check({tag, "_valid"}, mif.edge_wr_en, 1'b1);
      check({tag, "_mag"}, mif.edge_mag, exp_mag);
      check({tag, "_out"}, mif.edge_out, exp_out);
      @(posedge clk); #1;
      check({tag, "_once"}, mif.edge_wr_en, 1'b0);
      check({tag, "_hold"}, mif.edge_mag, exp_mag);
   endtask

   // Send one frame of 8 windows, edges where sel is set; expect done and count.
   task automatic frame(input string tag, input logic [7:0] sel, input logic [19:0] exp_cnt);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (sel[i]) drive(VSTEP, 8'd200);
         else        drive(FLAT, 8'd50);
      end
      @(negedge clk); idle();
      @(posedge clk); #1;
      check({tag, "_7th_valid"}, mif.edge_wr_en, 1'b1);
      check({tag, "_7th_done"}, mif.edge_frame_done, 1'b0);
      @(posedge clk); #1;
      check({tag, "_8th_valid"}, mif.edge_wr_en, 1'b1);
      check({tag, "_8th_done"}, mif.edge_frame_done, 1'b1);
      check({tag, "_count"}, mif.edge_count, exp_cnt);
      @(posedge clk); #1;
      check({tag, "_done_pulse"}, mif.edge_frame_done, 1'b0);
      check({tag, "_count_hold"}, mif.edge_count, exp_cnt);
   endtask

   // Reference monitor state
   logic            d_v   [3];
   logic [7:0]      d_mag [3];
   logic [7:0]      d_out [3];
   logic [7:0]      last_mag, last_out;
   logic [19:0]     exp_count;
   logic            exp_done;
   logic [8:0][7:0] cur_w;
   int              pos, run;

   // Predict every output cycle from the inputs sampled three edges earlier.
   always begin
      @(posedge clk); #1;
      if (!rst_n) begin
         for (int k = 0; k < 3; k++) begin
            d_v[k] = 1'b0; d_mag[k] = 8'd0; d_out[k] = 8'd0;
         end
         last_mag = 8'd0; last_out = 8'd0; exp_count = 20'd0; pos = 0; run = 0;
         check("m_rst_wr_en", mif.edge_wr_en, 1'b0);
         check("m_rst_mag", mif.edge_mag, 8'd0);
         check("m_rst_out", mif.edge_out, 8'd0);
         check("m_rst_done", mif.edge_frame_done, 1'b0);
         check("m_rst_count", mif.edge_count, 20'd0);
      end else begin
         for (int k = 2; k > 0; k--) begin
            d_v[k] = d_v[k-1]; d_mag[k] = d_mag[k-1]; d_out[k] = d_out[k-1];
         end
         cur_w = {mif.matrix_p33, mif.matrix_p32, mif.matrix_p31,
                  mif.matrix_p23, mif.matrix_p22, mif.matrix_p21,
                  mif.matrix_p13, mif.matrix_p12, mif.matrix_p11};
         d_v[0]   = mif.matrix_frame_wr_en;
         d_mag[0] = ref_mag(cur_w);
         d_out[0] = (d_mag[0] > mif.threshold) ? 8'hFF : 8'h00;
         exp_done = 1'b0;
         if (d_v[2]) begin
            last_mag = d_mag[2];
            last_out = d_out[2];
            if (d_out[2] == 8'hFF) run++;
            pos++;
            if (pos == 8) begin
               exp_done = 1'b1; exp_count = 20'(run); run = 0; pos = 0;
            end
         end
         check("m_wr_en", mif.edge_wr_en, d_v[2]);
         check("m_mag", mif.edge_mag, last_mag);
         check("m_out", mif.edge_out, last_out);
         check("m_done", mif.edge_frame_done, exp_done);
         check("m_count", mif.edge_count, exp_count);
         if (stream_phase && mif.edge_wr_en) stream_outs++;
      end
   end

   initial begin
      logic [8:0][7:0] w;
      drive(FLAT, 8'd0);
      idle();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      directed("flat", FLAT, 8'd50, 8'd0, 8'h00);
      directed("vstep_t200", VSTEP, 8'd200, 8'd255, 8'hFF);
      directed("vstep_t255", VSTEP, 8'd255, 8'd255, 8'h00);
      directed("thr39", STEP3, 8'd39, 8'd40, 8'hFF);
      directed("thr40", STEP3, 8'd40, 8'd40, 8'h00);
      directed("corner", CORNER, 8'd254, 8'd255, 8'hFF);

      // Back-to-back windows with different thresholds keep their own threshold.
      @(negedge clk); drive(STEP3, 8'd39);
      @(negedge clk); drive(STEP3, 8'd40);
      @(negedge clk); idle();
      @(posedge clk); #1;
      check("thr_inflight_a", mif.edge_out, 8'hFF);
      @(posedge clk); #1;
      check("thr_inflight_b", mif.edge_out, 8'h00);
      check("dir_frame_done", mif.edge_frame_done, 1'b1);
      check("dir_frame_count", mif.edge_count, 20'd4);

      // Fresh frame accounting from reset.
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      #1;
      check("rst_count_clear", mif.edge_count, 20'd0);
      frame("frame1", 8'b0101_0010, 20'd3);

      // Partial frame, then reset with windows in flight.
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); drive(VSTEP, 8'd200);
      end
      @(negedge clk); idle(); rst_n = 1'b0;
      #1;
      check("midrst_wr_en", mif.edge_wr_en, 1'b0);
      check("midrst_mag", mif.edge_mag, 8'd0);
      check("midrst_out", mif.edge_out, 8'd0);
      check("midrst_count", mif.edge_count, 20'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("midrst_no_stale", mif.edge_wr_en, 1'b0);
      end
      frame("frame2", 8'b1000_0001, 20'd2);

      // Streaming: alternate-cycle then back-to-back windows.
      stream_phase = 1'b1;
      for (int i = 0; i < 1280; i++) begin
         for (int k = 0; k < 9; k++) w[k] = 8'((i * (k + 1) * 7 + k * k * 29) & 255);
         @(negedge clk); drive(w, 8'((i * 37) & 255));
         if (i < 640) begin
            @(negedge clk); idle();
         end
      end
      @(negedge clk); idle();
      repeat (6) @(negedge clk);
      stream_phase = 1'b0;
      check("stream_count", stream_outs, 32'd1280);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sobel_edge_detect.md
# sobel_edge_detect

Pipelined Sobel gradient and threshold stage that consumes the 3x3 window stream produced by `matrix_generate_3x3` (`matrix_frame_wr_en`, `matrix_p11`..`matrix_p33`). For each valid window it emits a saturated 8-bit gradient magnitude and a binary edge pixel (0x00/0xFF) for the display/storage path. It also counts output pixels per frame, pulses end-of-frame and latches the per-frame edge-pixel count.

## Interface
- `IMG_WIDTH`, default 640: output pixels per line.
- `IMG_HEIGHT`, default 480: lines per frame.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `matrix_frame_wr_en`  in  1  window valid; one window per high cycle; may be high on consecutive cycles.
- `matrix_p11`..`matrix_p33`  in  8 each  window pixels, row-major (p11 top-left, p33 bottom-right).
- `threshold`  in  8  edge threshold; sampled only in cycles where `matrix_frame_wr_en` is high.
- `edge_wr_en`  out  1  output valid.
- `edge_mag`  out  8  saturated gradient magnitude.
- `edge_out`  out  8  0xFF if `edge_mag` > threshold, else 0x00.
- `edge_frame_done`  out  1  one-cycle pulse, coincident with the last `edge_wr_en` of a frame.
- `edge_count`  out  20  number of 0xFF pixels in the most recently completed frame.

## Operation
- Gradients:
  - Gx = (p13 + 2·p23 + p33) − (p11 + 2·p21 + p31).
  - Gy = (p31 + 2·p32 + p33) − (p11 + 2·p12 + p13).
- Pipeline:
  - **Stage 1** registers the four partial sums, unsigned 10-bit each (max 1020), plus the sampled threshold.
  - **Stage 2** registers |Gx| and |Gy|, 10-bit unsigned each, computed as larger minus smaller; no signed wrap.
  - **Stage 3** computes sum = |Gx| + |Gy| (11-bit, max 2040). It sets `edge_mag` = sum ≥ 255 ? 255 : sum[7:0], sets `edge_out` = (saturated mag > threshold) ? 0xFF : 0x00, and asserts `edge_wr_en`.
- A valid bit travels with each stage. Stage registers load only when their incoming valid is high; otherwise they hold their value.
- The threshold travels with its window. Changing `threshold` never affects windows already in flight.
- Frame counters:
  - `col_cnt` runs 0..IMG_WIDTH-1 and `row_cnt` runs 0..IMG_HEIGHT-1; both advance on each `edge_wr_en`.
  - A running edge count increments when `edge_out` = 0xFF.
  - At col = IMG_WIDTH-1 and row = IMG_HEIGHT-1:
    - pulse `edge_frame_done`;
    - load `edge_count` with the running count, including the current pixel;
    - clear the running count and both counters to 0 for the next frame.
- The running count cannot overflow, since 640·480 < 2^20.
- Gaps in `matrix_frame_wr_en` have no effect on counters. There is no timeout and no partial-frame flush.

## Timing
- Reset (async assert, sync release) forces:
  - outputs: `edge_wr_en`=0, `edge_mag`=0, `edge_out`=0, `edge_frame_done`=0, `edge_count`=0;
  - internal state: all valid bits, pipeline registers, counters and the running count cleared.
- Latency is fixed at 3 cycles. A window sampled at rising edge N appears on the outputs after edge N+2, with `edge_wr_en` high for exactly one cycle.
- Throughput is one window per clock. Output valid cycles replicate the input valid pattern, delayed by 3 cycles.
- No backpressure: the downstream stage must accept every `edge_wr_en` cycle.
- `edge_mag`/`edge_out` hold their last value while `edge_wr_en` is low.
- `edge_count` changes only in the `edge_frame_done` cycle and then holds.
- Reset asserted mid-frame or mid-pipeline discards all in-flight windows. No `edge_wr_en` occurs until 3 cycles after the first post-reset valid input, and the frame position restarts at (0,0).

## Test plan
- **Flat window:** all pixels = 100, threshold 50 → after 3 cycles, `edge_wr_en`=1, `edge_mag`=0, `edge_out`=0x00.
- **Vertical step, saturation:**
  - p11, p21, p31 = 0; other pixels = 255 → |Gx| = 1020, |Gy| = 0, `edge_mag`=255, `edge_out`=0xFF at threshold 200.
  - Same window at threshold 255 → `edge_out`=0x00.
- **Threshold boundary:** left column 10, middle 15, right column 20 → Gx=40, Gy=0, `edge_mag`=40.
  - threshold 39 → 0xFF.
  - threshold 40 → 0x00.
  - Change `threshold` on the cycle after a valid window → that window's result is unaffected.
- **Negative gradients:** only p11 = 255, rest 0 → |Gx| = 255, |Gy| = 255, sum 510, `edge_mag`=255. Confirms abs handling with no wrap.
- **Streaming pattern:** valid on every other cycle for 640 windows, then back-to-back for 640 windows, with incrementing pixel data → output count 1280. Each output equals the reference-model result, delayed exactly 3 cycles.
- **Frame accounting and reset:** with IMG_WIDTH=4 and IMG_HEIGHT=2, send 8 windows of which exactly 3 produce edges → `edge_frame_done` pulses with the 8th output and `edge_count`=3.
  - Then send 5 windows, assert `rst_n`=0 mid-pipeline, and release.
  - Required: all outputs 0, no stale `edge_wr_en`, and the next frame completes after 8 fresh windows.
